change_dispenser: RTL

//  Coin payout unit on the output side of the vending datapath. Takes a balance in jiao
//  (0.1 yuan) on start, pays it out greedily as 5y/1y/5j coin-eject pulses against a

---
 rtl/change_dispenser.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//
// Coin payout unit. On an accepted start it latches a balance in jiao and pays
// it out greedily (5y, then 1y, then 5j) as one-at-a-time eject pulses, drawing
// on a tracked coin inventory. Completion is flagged by a one-cycle done pulse;
// short tells whether part of the balance could not be paid.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-low reset
//   start        in   1   one-cycle payout request, taken only when idle
//   amount       in  12   balance to pay in jiao (5j=5, 1y=10, 5y=50)
//   load_inv     in   1   inventory write strobe, taken only when idle
//   load_c1/2/3  in   6   new 5j / 1y / 5y coin counts
//   eject_5j     out  1   5 jiao coin eject pulse
//   eject_1y     out  1   1 yuan coin eject pulse
//   eject_5y     out  1   5 yuan coin eject pulse
//   busy         out  1   payout in progress (through the done cycle)
//   done         out  1   one-cycle completion pulse
//   short        out  1   remainder left unpaid; valid with done, held until
//                         the next accepted start
//   remaining    out 12   balance still owed
//   inv_c1/2/3   out  6   current 5j / 1y / 5y inventory
//   state_dbg    out  3   current FSM state encoding (observation only)
//
// Handshake: start and load_inv are single-cycle strobes sampled on the rising
// clock edge; the block has no back-pressure output other than busy, and any
// strobe seen while busy is dropped without effect.
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned INIT_C1   = 20,
    parameter int unsigned INIT_C2   = 20,
    parameter int unsigned INIT_C3   = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        load_inv,
    input  logic [5:0]  load_c1,
    input  logic [5:0]  load_c2,
    input  logic [5:0]  load_c3,
    output logic        eject_5j,
    output logic        eject_1y,
    output logic        eject_5y,
    output logic        busy,
    output logic        done,
    output logic        short,
    output logic [11:0] remaining,
    output logic [5:0]  inv_c1,
    output logic [5:0]  inv_c2,
    output logic [5:0]  inv_c3,
    output logic [2:0]  state_dbg
);

    // One counter serves both the pulse-high and gap-low phases, so it is
    // sized for the longer of the two.
    localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    localparam logic [5:0] INIT_C1_V = 6'(INIT_C1);
    localparam logic [5:0] INIT_C2_V = 6'(INIT_C2);
    localparam logic [5:0] INIT_C3_V = 6'(INIT_C3);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5J   = 2'd1,
        COIN_1Y   = 2'd2,
        COIN_5Y   = 2'd3
    } coin_t;

    state_t           state;
    state_t           state_next;
    coin_t            pick;
    coin_t            coin;
    logic [11:0]      coin_value;
    logic [CNT_W-1:0] cnt;
    logic             pulse_last;
    logic             gap_last;

    assign pulse_last = (cnt == PULSE_LAST);
    assign gap_last   = (cnt == GAP_LAST);

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign state_dbg = state;

    // Greedy pick: largest coin that both fits the balance and is in stock.
    // Checking value <= remaining and count != 0 here is what keeps the
    // balance and the inventory from ever wrapping below zero.
    always_comb begin
        pick = COIN_NONE;
        if (remaining >= 12'd50 && inv_c3 != 6'd0) begin
            pick = COIN_5Y;
        end else if (remaining >= 12'd10 && inv_c2 != 6'd0) begin
            pick = COIN_1Y;
        end else if (remaining >= 12'd5 && inv_c1 != 6'd0) begin
            pick = COIN_5J;
        end
    end

    always_comb begin
        coin_value = 12'd0;
        case (coin)
            COIN_5J: coin_value = 12'd5;
            COIN_1Y: coin_value = 12'd10;
            COIN_5Y: coin_value = 12'd50;
            default: coin_value = 12'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SELECT;
                end
            end
            S_SELECT: begin
                if (pick != COIN_NONE) begin
                    state_next = S_PULSE;
                end else begin
                    state_next = S_FINISH;
                end
            end
            S_PULSE: begin
                if (pulse_last) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_next = S_SELECT;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: balance, inventory, phase counter and the registered ejects.
    // Async reset clears the eject flops directly so a pulse in flight drops
    // the moment reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            coin      <= COIN_NONE;
            eject_5j  <= 1'b0;
            eject_1y  <= 1'b0;
            eject_5y  <= 1'b0;
            short     <= 1'b0;
            remaining <= 12'd0;
            inv_c1    <= INIT_C1_V;
            inv_c2    <= INIT_C2_V;
            inv_c3    <= INIT_C3_V;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        remaining <= amount;
                        short     <= 1'b0;
                    end
                    // Taken alongside start as well; SELECT then sees the new counts.
                    if (load_inv) begin
                        inv_c1 <= load_c1;
                        inv_c2 <= load_c2;
                        inv_c3 <= load_c3;
                    end
                end
                S_SELECT: begin
                    cnt <= '0;
                    if (pick != COIN_NONE) begin
                        coin     <= pick;
                        eject_5j <= (pick == COIN_5J);
                        eject_1y <= (pick == COIN_1Y);
                        eject_5y <= (pick == COIN_5Y);
                    end else begin
                        short <= (remaining != 12'd0);
                    end
                end
                S_PULSE: begin
                    if (pulse_last) begin
                        cnt       <= '0;
                        eject_5j  <= 1'b0;
                        eject_1y  <= 1'b0;
                        eject_5y  <= 1'b0;
                        remaining <= remaining - coin_value;
                        case (coin)
                            COIN_5J: inv_c1 <= inv_c1 - 6'd1;
                            COIN_1Y: inv_c2 <= inv_c2 - 6'd1;
                            COIN_5Y: inv_c3 <= inv_c3 - 6'd1;
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
